// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and execute: splits a 16-bit instruction into a registered
// control bundle, holds a one-cycle load-use interlock, honours branch flush and counts interlock stalls.
module instr_decode_stage #(
  parameter int INSTR_W = 16,
  parameter int RADDR_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [RADDR_W-1:0] out_rd,
  output logic [RADDR_W-1:0] out_rs1,
  output logic [RADDR_W-1:0] out_rs2,
  output logic [7:0]         out_imm,
  output logic               out_use_imm,
  output logic               out_reg_we,
  output logic               out_mem_re,
  output logic               out_mem_we,
  output logic               out_flags_we,
  output logic               out_is_branch,
  output logic               out_rs1_used,
  output logic               out_rs2_used,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [3:0] OP_LDUR = 4'hA;

  logic [3:0]         op;
  logic [RADDR_W-1:0] rd_f, rn_f, rm_f;
  logic [7:0]         imm8, shamt_imm;

  assign op        = in_instr[15:12];
  assign rd_f      = RADDR_W'(in_instr[11:10]);
  assign rn_f      = RADDR_W'(in_instr[9:8]);
  assign rm_f      = RADDR_W'(in_instr[7:6]);
  assign imm8      = in_instr[7:0];
  assign shamt_imm = {5'b0, in_instr[2:0]};

  logic [RADDR_W-1:0] d_rd, d_rs1, d_rs2;
  logic [7:0]         d_imm;
  logic d_use_imm, d_reg_we, d_mem_re, d_mem_we, d_flags_we, d_is_branch, d_rs1_used, d_rs2_used;

  always_comb begin
    d_rd        = '0;
    d_rs1       = '0;
    d_rs2       = '0;
    d_imm       = '0;
    d_use_imm   = 1'b0;
    d_reg_we    = 1'b0;
    d_mem_re    = 1'b0;
    d_mem_we    = 1'b0;
    d_flags_we  = 1'b0;
    d_is_branch = 1'b0;
    d_rs1_used  = 1'b0;
    d_rs2_used  = 1'b0;
    case (op)
      4'h0, 4'h2, 4'h4, 4'h5, 4'h6: begin
        d_rd = rd_f; d_rs1 = rn_f; d_rs2 = rm_f;
        d_rs1_used = 1'b1; d_rs2_used = 1'b1; d_reg_we = 1'b1;
      end
      4'h1, 4'h3: begin
        d_rd = rd_f; d_rs1 = rn_f; d_imm = imm8;
        d_rs1_used = 1'b1; d_use_imm = 1'b1; d_reg_we = 1'b1;
      end
      4'h7, 4'hF: begin
        d_rd = rd_f; d_rs1 = rn_f;
        d_rs1_used = 1'b1; d_reg_we = 1'b1;
      end
      4'h8, 4'h9: begin
        d_rd = rd_f; d_rs1 = rn_f; d_imm = shamt_imm;
        d_rs1_used = 1'b1; d_use_imm = 1'b1; d_reg_we = 1'b1;
      end
      4'hA: begin
        d_rd = rd_f; d_rs1 = rn_f; d_imm = imm8;
        d_rs1_used = 1'b1; d_use_imm = 1'b1; d_mem_re = 1'b1; d_reg_we = 1'b1;
      end
      // Stores take their data register from the rd field.
      4'hB: begin
        d_rs1 = rn_f; d_rs2 = rd_f; d_imm = imm8;
        d_rs1_used = 1'b1; d_rs2_used = 1'b1; d_use_imm = 1'b1; d_mem_we = 1'b1;
      end
      4'hC: begin
        d_rs1 = rn_f; d_rs2 = rm_f;
        d_rs1_used = 1'b1; d_rs2_used = 1'b1; d_flags_we = 1'b1;
      end
      4'hD: begin
        d_imm = imm8; d_is_branch = 1'b1;
      end
      default: begin
        d_rd = rd_f; d_imm = imm8;
        d_use_imm = 1'b1; d_reg_we = 1'b1;
      end
    endcase
  end

  logic hazard, accept, fire, stall_inc;

  assign hazard = in_valid && out_valid && (out_opcode == OP_LDUR) &&
                  ((d_rs1_used && (d_rs1 == out_rd)) || (d_rs2_used && (d_rs2 == out_rd)));
  assign in_ready  = rst_n && !flush && !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign stall_inc = hazard && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_opcode    <= '0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_imm       <= '0;
      out_use_imm   <= 1'b0;
      out_reg_we    <= 1'b0;
      out_mem_re    <= 1'b0;
      out_mem_we    <= 1'b0;
      out_flags_we  <= 1'b0;
      out_is_branch <= 1'b0;
      out_rs1_used  <= 1'b0;
      out_rs2_used  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_opcode    <= op;
      out_rd        <= d_rd;
      out_rs1       <= d_rs1;
      out_rs2       <= d_rs2;
      out_imm       <= d_imm;
      out_use_imm   <= d_use_imm;
      out_reg_we    <= d_reg_we;
      out_mem_re    <= d_mem_re;
      out_mem_we    <= d_mem_we;
      out_flags_we  <= d_flags_we;
      out_is_branch <= d_is_branch;
      out_rs1_used  <= d_rs1_used;
      out_rs2_used  <= d_rs2_used;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

  // Only interlock stalls count; a hazard masked by backpressure is not an interlock cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
